byte_unstriping_cond: RTL and testbench

Receive-side merge that recombines two byte lanes into one byte stream at clk_2f. It is the inverse of the transmit-side byte striper, which sends byte 0 on lane 0, byte 1 on lane 1, byte 2 on lane 0, and so on. Each lane has a small FIFO to absorb inter-lane skew. Output is strict round-robin starting at lane 0, and the block never skips a lane.

---
 rtl/byte_unstriping_cond_if.sv | 26 ++
 rtl/byte_unstriping_cond.sv | 122 ++++++++++++
 tb/tb_byte_unstriping_cond.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_unstriping_cond_if.sv
// Lane inputs and merged-stream outputs of the two-lane byte unstriper.
// Latency: none (signal bundle only).
// Backpressure: none; lanes are strobe-only and the merge side never stalls them.
interface byte_unstriping_cond_if;
    logic [7:0] lane_0_in;
    logic       valid_0_in;
    logic [7:0] lane_1_in;
    logic       valid_1_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       sel_out;
    logic       overflow_0;
    logic       overflow_1;

    // Source side: drives the lanes, observes the merged stream.
    modport master (
        output lane_0_in, valid_0_in, lane_1_in, valid_1_in,
        input  data_out, valid_out, sel_out, overflow_0, overflow_1
    );

    // Unstriper side.
    modport slave (
        input  lane_0_in, valid_0_in, lane_1_in, valid_1_in,
        output data_out, valid_out, sel_out, overflow_0, overflow_1
    );
endinterface

// File: rtl/byte_unstriping_cond.sv
// Merges two striped byte lanes back into one stream, strict round-robin from lane 0.
// Latency: a byte pushed on edge N can leave no earlier than edge N+1 (registered out).
// Backpressure: none upstream; a byte arriving at a full lane FIFO is dropped and flagged sticky.
module byte_unstriping_cond #(
    parameter int DEPTH = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    byte_unstriping_cond_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Per-lane FIFO storage and pointers, indexed [lane].
    logic [7:0]    mem_q    [2][DEPTH];
    logic [7:0]    mem_d    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q    [2];
    logic [CW-1:0] cnt_d    [2];

    // Output-side state.
    logic       sel_q, sel_d;
    logic [7:0] dat_q, dat_d;
    logic       vld_q, vld_d;
    logic [1:0] ovf_q, ovf_d;

    // Lane inputs gathered into arrays so both lanes share one code path.
    logic [7:0] lane_dat [2];
    logic [1:0] lane_vld;
    logic [1:0] full;
    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] drop;

    // Per-lane push/pop/drop decisions, all taken from pre-edge FIFO state.
    always_comb begin
        lane_dat[0] = bus.lane_0_in;
        lane_dat[1] = bus.lane_1_in;
        lane_vld    = {bus.valid_1_in, bus.valid_0_in};
        full        = '0;
        pop         = '0;
        push        = '0;
        drop        = '0;
        for (int k = 0; k < 2; k++) begin
            full[k] = (cnt_q[k] == FULL_CNT);
            // Only the lane whose turn it is may be popped; never skip ahead.
            pop[k]  = (sel_q == k[0]) && (cnt_q[k] != '0);
            // A full FIFO still takes a byte if its head leaves on the same edge.
            push[k] = lane_vld[k] && (!full[k] || pop[k]);
            drop[k] = lane_vld[k] && full[k] && !pop[k];
        end
    end

    // Next-state: FIFO updates, round-robin output, sticky overflow; reset wins.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q;

        if (!reset) begin
            // Buffered bytes are discarded; storage contents are don't-care once counts are zero.
            for (int k = 0; k < 2; k++) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                cnt_d[k]    = '0;
            end
            sel_d = 1'b0;
            dat_d = 8'h00;
            vld_d = 1'b0;
            ovf_d = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    // When full with a concurrent pop, tail == head: the head byte is read
                    // from mem_q below, so overwriting that slot in mem_d is safe.
                    mem_d[k][wr_ptr_q[k]] = lane_dat[k];
                    wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
                end
                cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
                if (drop[k]) begin
                    ovf_d[k] = 1'b1;
                end
            end

            if (pop != 2'b00) begin
                dat_d = mem_q[sel_q][rd_ptr_q[sel_q]];
                vld_d = 1'b1;
                sel_d = ~sel_q;
            end
        end
    end

    // State registers; reset is folded into the next-state logic, so no reset term here.
    always_ff @(posedge clk_2f) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        sel_q    <= sel_d;
        dat_q    <= dat_d;
        vld_q    <= vld_d;
        ovf_q    <= ovf_d;
    end

    assign bus.data_out   = dat_q;
    assign bus.valid_out  = vld_q;
    assign bus.sel_out    = sel_q;
    assign bus.overflow_0 = ovf_q[0];
    assign bus.overflow_1 = ovf_q[1];
endmodule

// File: tb/tb_byte_unstriping_cond.sv
// Directed bench: a vector table for reset/aligned/skewed streams plus hand sequences
// for overflow, full push-with-pop, and mid-stream reset.
module tb_byte_unstriping_cond;
    logic clk_2f = 1'b0;
    logic reset  = 1'b0;

    byte_unstriping_cond_if bus ();

    byte_unstriping_cond #(.DEPTH(4)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ev;
        logic [7:0] ed;
        logic       es;
        logic       eo0;
        logic       eo1;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] got  [$];
    logic [7:0] exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ev,
                       input logic [7:0] ed, input logic es, input logic eo0, input logic eo1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ev = ev; v.ed = ed; v.es = es; v.eo0 = eo0; v.eo1 = eo1;
        vecs.push_back(v);
    endtask

    // Drive one edge worth of inputs, clock it, sample 1 ns after, record any output byte.
    task automatic apply(input logic rst, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
        reset          = rst;
        bus.valid_0_in = v0;
        bus.lane_0_in  = d0;
        bus.valid_1_in = v1;
        bus.lane_1_in  = d1;
        @(posedge clk_2f);
        #1;
        if (bus.valid_out === 1'b1) got.push_back(bus.data_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic cmp_seq(input string name);
        chk({name, " length"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_0_in = 1'b0;
        bus.lane_0_in  = 8'h00;
        bus.valid_1_in = 1'b0;
        bus.lane_1_in  = 8'h00;

        // rst v0 d0   v1 d1    ev ed   es eo0 eo1
        // Reset held with lane 0 active: FF must never appear.
        add(0, 1, 8'hFF, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        // Aligned lanes.
        add(1, 1, 8'hA0, 1, 8'hA1,  0, 8'h00, 0, 0, 0);
        add(1, 1, 8'hA2, 1, 8'hA3,  1, 8'hA0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'hA1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'hA2, 1, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'hA3, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  0, 8'hA3, 0, 0, 0);
        // Lane 1 lagging lane 0 by three bytes.
        add(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h10, 0, 8'h00,  0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h12, 0, 8'h00,  1, 8'h10, 1, 0, 0);
        add(1, 1, 8'h14, 0, 8'h00,  0, 8'h10, 1, 0, 0);
        add(1, 0, 8'h00, 1, 8'h11,  0, 8'h10, 1, 0, 0);
        add(1, 0, 8'h00, 1, 8'h13,  1, 8'h11, 0, 0, 0);
        add(1, 0, 8'h00, 1, 8'h15,  1, 8'h12, 1, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'h13, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'h14, 1, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  1, 8'h15, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00,  0, 8'h15, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            chk($sformatf("vec%0d valid_out", i), bus.valid_out, vecs[i].ev);
            chk($sformatf("vec%0d data_out",  i), bus.data_out,  vecs[i].ed);
            chk($sformatf("vec%0d sel_out",   i), bus.sel_out,   vecs[i].es);
            chk($sformatf("vec%0d overflow_0", i), bus.overflow_0, vecs[i].eo0);
            chk($sformatf("vec%0d overflow_1", i), bus.overflow_1, vecs[i].eo1);
        end
        got.delete();

        // Overflow: six lane-0 bytes with lane 1 idle, B5 lands on a full FIFO.
        apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 8'(8'hB0 + i), 1'b0, 8'h00);
            if (i == 1) begin
                chk("ovf B0 valid", bus.valid_out, 1'b1);
                chk("ovf B0 data",  bus.data_out,  8'hB0);
            end
            if (i == 4) chk("ovf before drop", bus.overflow_0, 1'b0);
            if (i == 5) chk("ovf after drop",  bus.overflow_0, 1'b1);
        end
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'hC0 + i));
        idle(8);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'hB0 + i));
            exp_q.push_back(8'(8'hC0 + i));
        end
        cmp_seq("ovf stream");
        chk("ovf overflow_0 sticky", bus.overflow_0, 1'b1);
        chk("ovf overflow_1",        bus.overflow_1, 1'b0);

        // Full FIFO 0 with sel_out=0, then push D0 on the edge that pops its head.
        apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("full reset clears overflow_0", bus.overflow_0, 1'b0);
        got.delete();
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 8'(8'hF0 + i), 1'b0, 8'h00);
        apply(1'b1, 1'b0, 8'h00, 1'b1, 8'h50);
        idle(1);
        chk("full sel before D0", bus.sel_out, 1'b0);
        apply(1'b1, 1'b1, 8'hD0, 1'b0, 8'h00);
        chk("full push+pop overflow_0", bus.overflow_0, 1'b0);
        // Count must still be 4: a lone push with no pop now has to be dropped.
        apply(1'b1, 1'b1, 8'hEE, 1'b1, 8'h51);
        chk("full count held at depth", bus.overflow_0, 1'b1);
        for (int i = 2; i < 5; i++) apply(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'h50 + i));
        idle(10);
        exp_q = '{8'hF0, 8'h50, 8'hF1, 8'h51, 8'hF2, 8'h52,
                  8'hF3, 8'h53, 8'hF4, 8'h54, 8'hD0};
        cmp_seq("full stream");

        // Mid-stream reset with bytes buffered in both lanes and sel_out=1.
        apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        got.delete();
        apply(1'b1, 1'b0, 8'h00, 1'b1, 8'h70);
        apply(1'b1, 1'b0, 8'h00, 1'b1, 8'h71);
        apply(1'b1, 1'b1, 8'h60, 1'b1, 8'h72);
        apply(1'b1, 1'b1, 8'h61, 1'b0, 8'h00);
        chk("mid pre valid", bus.valid_out, 1'b1);
        chk("mid pre data",  bus.data_out,  8'h60);
        chk("mid pre sel",   bus.sel_out,   1'b1);
        apply(1'b0, 1'b1, 8'h99, 1'b1, 8'h98);
        chk("mid rst valid", bus.valid_out, 1'b0);
        chk("mid rst data",  bus.data_out,  8'h00);
        chk("mid rst sel",   bus.sel_out,   1'b0);
        got.delete();
        apply(1'b1, 1'b0, 8'h00, 1'b1, 8'hE1);
        chk("mid E1 in valid", bus.valid_out, 1'b0);
        apply(1'b1, 1'b1, 8'hE0, 1'b0, 8'h00);
        chk("mid E0 in valid", bus.valid_out, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("mid E0 out data", bus.data_out, 8'hE0);
        chk("mid E0 out sel",  bus.sel_out,  1'b1);
        apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("mid E1 out data", bus.data_out, 8'hE1);
        idle(4);
        exp_q = '{8'hE0, 8'hE1};
        cmp_seq("mid stream");
        chk("mid overflow_0", bus.overflow_0, 1'b0);
        chk("mid overflow_1", bus.overflow_1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
